// File: rtl/vga_sync_monitor.sv
// Passive VGA timing checker: measures line period, hSync pulse width, lines and
// active lines per frame, publishes one value by sel, and flags lock and timing errors.
module vga_sync_monitor #(
    parameter int CNT_W       = 16,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             ClkPort,
    input  logic             Reset,
    input  logic             hSync,
    input  logic             vSync,
    input  logic             bright,
    input  logic [1:0]       sel,
    output logic [CNT_W-1:0] meas,
    output logic             locked,
    output logic             err,
    output logic             frame_tick
);

    localparam logic [1:0]       IDLE    = 2'd0;
    localparam logic [1:0]       SYNC    = 2'd1;
    localparam logic [1:0]       MEAS    = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [3:0]       LOCK_N  = 4'(LOCK_FRAMES);

    logic [1:0]       state_reg;
    logic             hs_q;
    logic             vs_q;
    logic [CNT_W-1:0] line_cnt_reg;
    logic [CNT_W-1:0] hp_cnt_reg;
    logic [CNT_W-1:0] lines_cnt_reg;
    logic [CNT_W-1:0] act_cnt_reg;
    logic [CNT_W-1:0] last_period_reg;
    logic [CNT_W-1:0] last_pulse_reg;
    logic [CNT_W-1:0] ref_period_reg;
    logic [CNT_W-1:0] ref_pulse_reg;
    logic             line_bright_reg;
    logic             ref_valid_reg;
    logic             unstable_reg;
    logic [3:0]       match_cnt_reg;
    logic [CNT_W-1:0] snap_reg [4];

    logic             hfall;
    logic             vfall;
    logic             line_end;
    logic             diff_now;
    logic             sat_hit;
    logic             publish;
    logic             pub_unstable;
    logic             pub_same;
    logic [CNT_W-1:0] pub_val [4];
    logic [3:0]       same_vec;
    logic [3:0]       match_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign hfall    = hs_q & ~hSync;
    assign vfall    = vs_q & ~vSync;
    // A line ending on the vfall edge still belongs to the frame being published.
    assign line_end = hfall && (state_reg == MEAS);
    assign diff_now = line_end && ref_valid_reg &&
                      ((line_cnt_reg != ref_period_reg) || (hp_cnt_reg != ref_pulse_reg));
    assign sat_hit  = (state_reg != IDLE) &&
                      ((line_cnt_reg == CNT_MAX) || (hp_cnt_reg == CNT_MAX) ||
                       (lines_cnt_reg == CNT_MAX) || (act_cnt_reg == CNT_MAX));
    assign publish      = vfall && (state_reg == MEAS) && !sat_hit;
    assign pub_unstable = unstable_reg | diff_now;

    always_comb begin
        pub_val[0] = line_end ? line_cnt_reg : last_period_reg;
        pub_val[1] = line_end ? hp_cnt_reg : last_pulse_reg;
        pub_val[2] = lines_cnt_reg;
        pub_val[3] = (line_end && line_bright_reg) ? sat_inc(act_cnt_reg) : act_cnt_reg;
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_same
            assign same_vec[gi] = (pub_val[gi] == snap_reg[gi]);
        end
    endgenerate
    assign pub_same = &same_vec;

    always_comb begin
        match_next = 4'd0;
        if (!pub_unstable && pub_same)
            match_next = (match_cnt_reg >= LOCK_N) ? LOCK_N : match_cnt_reg + 4'd1;
        else if (!pub_unstable)
            match_next = 4'd1;
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            hs_q            <= 1'b1;
            vs_q            <= 1'b1;
            line_cnt_reg    <= '0;
            hp_cnt_reg      <= '0;
            line_bright_reg <= 1'b0;
            last_period_reg <= '0;
            last_pulse_reg  <= '0;
        end else begin
            hs_q <= hSync;
            vs_q <= vSync;
            if (hfall) begin
                line_cnt_reg    <= CNT_ONE;
                hp_cnt_reg      <= CNT_ONE;
                line_bright_reg <= bright;
                last_period_reg <= line_cnt_reg;
                last_pulse_reg  <= hp_cnt_reg;
            end else begin
                line_cnt_reg    <= sat_inc(line_cnt_reg);
                line_bright_reg <= line_bright_reg | bright;
                if (!hs_q && !hSync)
                    hp_cnt_reg <= sat_inc(hp_cnt_reg);
            end
        end
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            state_reg      <= IDLE;
            lines_cnt_reg  <= '0;
            act_cnt_reg    <= '0;
            ref_period_reg <= '0;
            ref_pulse_reg  <= '0;
            ref_valid_reg  <= 1'b0;
            unstable_reg   <= 1'b0;
            match_cnt_reg  <= 4'd0;
            locked         <= 1'b0;
            err            <= 1'b0;
            frame_tick     <= 1'b0;
            for (int i = 0; i < 4; i++) snap_reg[i] <= '0;
        end else begin
            frame_tick <= publish;
            if (sat_hit) begin
                // Stuck hSync or missing vSync: drop lock and hunt for sync again.
                state_reg     <= IDLE;
                lines_cnt_reg <= '0;
                act_cnt_reg   <= '0;
                ref_valid_reg <= 1'b0;
                unstable_reg  <= 1'b0;
                match_cnt_reg <= 4'd0;
                locked        <= 1'b0;
                err           <= 1'b1;
            end else begin
                case (state_reg)
                    IDLE: if (hfall) state_reg <= SYNC;
                    SYNC: begin
                        if (vfall) begin
                            state_reg     <= MEAS;
                            lines_cnt_reg <= hfall ? CNT_ONE : '0;
                            act_cnt_reg   <= '0;
                            ref_valid_reg <= 1'b0;
                            unstable_reg  <= 1'b0;
                        end
                    end
                    MEAS: begin
                        if (vfall) begin
                            for (int i = 0; i < 4; i++) snap_reg[i] <= pub_val[i];
                            match_cnt_reg <= match_next;
                            locked        <= (match_next >= LOCK_N);
                            if (locked && (!pub_same || pub_unstable))
                                err <= 1'b1;
                            lines_cnt_reg <= hfall ? CNT_ONE : '0;
                            act_cnt_reg   <= '0;
                            ref_valid_reg <= 1'b0;
                            unstable_reg  <= 1'b0;
                        end else if (hfall) begin
                            lines_cnt_reg <= sat_inc(lines_cnt_reg);
                            if (line_bright_reg)
                                act_cnt_reg <= sat_inc(act_cnt_reg);
                            if (!ref_valid_reg) begin
                                ref_period_reg <= line_cnt_reg;
                                ref_pulse_reg  <= hp_cnt_reg;
                                ref_valid_reg  <= 1'b1;
                            end else if (diff_now) begin
                                unstable_reg <= 1'b1;
                            end
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset)
            meas <= '0;
        else
            meas <= snap_reg[sel];
    end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a scaled-down VGA stream
// (24-cycle lines, 4-cycle hSync pulse, 12 lines, 8 active lines, 10-bit counters).
module tb_vga_sync_monitor;

    localparam int CW = 10;
    localparam int P  = 24;
    localparam int H  = 4;
    localparam int L  = 12;
    localparam int A  = 8;

    logic          ClkPort = 1'b0;
    logic          Reset   = 1'b0;
    logic          hSync   = 1'b1;
    logic          vSync   = 1'b1;
    logic          bright  = 1'b0;
    logic [1:0]    sel     = 2'd0;
    logic [CW-1:0] meas;
    logic          locked;
    logic          err;
    logic          frame_tick;

    int compared   = 0;
    int mismatched = 0;
    int cyc_no     = 0;
    int ticks      = 0;
    int tick_cyc   = 0;
    int vfall_cyc  = 0;
    int frame_no   = 0;
    logic          tick_locked;
    logic          tick_err;
    logic [CW-1:0] cap [4];

    always #5 ClkPort = ~ClkPort;

    vga_sync_monitor #(.CNT_W(CW), .LOCK_FRAMES(2)) dut (
        .ClkPort    (ClkPort),
        .Reset      (Reset),
        .hSync      (hSync),
        .vSync      (vSync),
        .bright     (bright),
        .sel        (sel),
        .meas       (meas),
        .locked     (locked),
        .err        (err),
        .frame_tick (frame_tick)
    );

    // Observe outputs at the falling edge, then drive the next input set; sel rotates every cycle.
    task automatic cyc(input logic h, input logic v, input logic b);
        @(negedge ClkPort);
        if (frame_tick === 1'b1) begin
            ticks++;
            tick_locked = locked;
            tick_err    = err;
            tick_cyc    = cyc_no;
        end
        cap[sel] = meas;
        hSync    = h;
        vSync    = v;
        bright   = b;
        sel      = sel + 2'd1;
        cyc_no++;
    endtask

    task automatic run_frame(input int nlines, input int long_ln, input bit coinc);
        int   per;
        int   voff;
        logic h;
        logic v;
        logic b;
        ticks = 0;
        voff  = coinc ? 0 : 10;
        for (int ln = 0; ln < nlines; ln++) begin
            per = (ln == long_ln) ? P + 4 : P;
            for (int c = 0; c < per; c++) begin
                h = (c < H) ? 1'b0 : 1'b1;
                v = ((ln == 0 && c >= voff) || ln == 1 || (ln == 2 && c < voff)) ? 1'b0 : 1'b1;
                b = (ln >= 3 && ln < 3 + A && c >= H + 2 && c < per - 2);
                if (ln == 0 && c == voff) vfall_cyc = cyc_no;
                cyc(h, v, b);
            end
        end
        frame_no++;
        $display("frame %0d: lines=%0d ticks=%0d locked=%0b err=%0b meas=%0d/%0d/%0d/%0d",
                 frame_no, nlines, ticks, tick_locked, tick_err, cap[0], cap[1], cap[2], cap[3]);
    endtask

    task automatic do_reset;
        @(negedge ClkPort);
        Reset = 1'b1;
        @(negedge ClkPort);
        @(negedge ClkPort);
        Reset = 1'b0;
    endtask

    task automatic nominal_stream(input string tag);
        int            exp_t [4] = '{0, 1, 1, 1};
        logic          exp_l [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [CW-1:0] exp_m [4] = '{10'd24, 10'd4, 10'd12, 10'd8};
        for (int f = 0; f < 4; f++) begin
            run_frame(L, -1, 1'b0);
            compared++;
            if (ticks !== exp_t[f]) begin
                mismatched++;
                $display("FAIL %s_ticks f%0d: got %0d want %0d", tag, f, ticks, exp_t[f]);
            end
            if (exp_t[f] == 1) begin
                compared++;
                if (tick_cyc !== vfall_cyc + 1) begin
                    mismatched++;
                    $display("FAIL %s_tick_latency f%0d: got %0d want %0d", tag, f, tick_cyc, vfall_cyc + 1);
                end
                compared++;
                if (tick_locked !== exp_l[f]) begin
                    mismatched++;
                    $display("FAIL %s_locked f%0d: got %0b want %0b", tag, f, tick_locked, exp_l[f]);
                end
                compared++;
                if (tick_err !== 1'b0) begin
                    mismatched++;
                    $display("FAIL %s_err f%0d: got %0b want 0", tag, f, tick_err);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (cap[i] !== exp_m[i]) begin
                mismatched++;
                $display("FAIL %s_meas sel%0d: got %0d want %0d", tag, i, cap[i], exp_m[i]);
            end
        end
    endtask

    task automatic test_reset;
        #2 Reset = 1'b1;
        #1;
        compared++;
        if ({meas, locked, err, frame_tick} !== '0) begin
            mismatched++;
            $display("FAIL reset_async: got meas=%0d locked=%0b err=%0b tick=%0b want all 0",
                     meas, locked, err, frame_tick);
        end
        @(negedge ClkPort);
        @(negedge ClkPort);
        compared++;
        if ({meas, locked, err, frame_tick} !== '0) begin
            mismatched++;
            $display("FAIL reset_held: got meas=%0d locked=%0b err=%0b tick=%0b want all 0",
                     meas, locked, err, frame_tick);
        end
        Reset = 1'b0;
    endtask

    task automatic test_nominal;
        nominal_stream("nominal");
    endtask

    task automatic test_reset_midframe;
        run_frame(5, -1, 1'b0);
        #1 Reset = 1'b1;
        #1;
        compared++;
        if ({meas, locked, err, frame_tick} !== '0) begin
            mismatched++;
            $display("FAIL midreset_async: got meas=%0d locked=%0b err=%0b tick=%0b want all 0",
                     meas, locked, err, frame_tick);
        end
        @(negedge ClkPort);
        @(negedge ClkPort);
        Reset = 1'b0;
        nominal_stream("after_reset");
    endtask

    task automatic test_short_frame;
        int   nl    [5] = '{L, L - 1, L, L, L};
        int   exp_l [5] = '{1, 1, 0, 0, 1};
        int   exp_e [5] = '{0, 0, 1, 1, 1};
        for (int f = 0; f < 5; f++) begin
            run_frame(nl[f], -1, 1'b0);
            compared++;
            if (ticks !== 1 || tick_locked !== exp_l[f][0] || tick_err !== exp_e[f][0]) begin
                mismatched++;
                $display("FAIL short_publish f%0d: got ticks=%0d locked=%0b err=%0b want 1/%0d/%0d",
                         f, ticks, tick_locked, tick_err, exp_l[f], exp_e[f]);
            end
            if (f == 2) begin
                compared++;
                if (cap[2] !== 10'd11) begin
                    mismatched++;
                    $display("FAIL short_lines: got %0d want 11", cap[2]);
                end
            end
        end
    endtask

    task automatic test_unstable;
        do_reset();
        for (int f = 0; f < 4; f++) run_frame(L, -1, 1'b0);
        run_frame(L, 5, 1'b0);
        compared++;
        if (tick_locked !== 1'b1) begin
            mismatched++;
            $display("FAIL unstable_pre_locked: got %0b want 1", tick_locked);
        end
        run_frame(L, -1, 1'b0);
        compared++;
        if (ticks !== 1 || tick_locked !== 1'b0 || tick_err !== 1'b1) begin
            mismatched++;
            $display("FAIL unstable_publish: got ticks=%0d locked=%0b err=%0b want 1/0/1",
                     ticks, tick_locked, tick_err);
        end
        compared++;
        if (cap[0] !== 10'd24 || cap[2] !== 10'd12) begin
            mismatched++;
            $display("FAIL unstable_snapshot: got period=%0d lines=%0d want 24/12", cap[0], cap[2]);
        end
        run_frame(L, -1, 1'b0);
        compared++;
        if (tick_locked !== 1'b0) begin
            mismatched++;
            $display("FAIL unstable_match_restart: got locked=%0b want 0", tick_locked);
        end
        run_frame(L, -1, 1'b0);
        compared++;
        if (tick_locked !== 1'b1) begin
            mismatched++;
            $display("FAIL unstable_relock: got locked=%0b want 1", tick_locked);
        end
    endtask

    task automatic test_saturation;
        do_reset();
        for (int f = 0; f < 4; f++) run_frame(L, -1, 1'b0);
        ticks = 0;
        for (int i = 0; i < 1100; i++) cyc(1'b1, 1'b1, 1'b0);
        $display("hold: hSync high for 1100 cycles, ticks=%0d locked=%0b err=%0b", ticks, locked, err);
        compared++;
        if (ticks !== 0 || locked !== 1'b0 || err !== 1'b1) begin
            mismatched++;
            $display("FAIL sat_hold: got ticks=%0d locked=%0b err=%0b want 0/0/1", ticks, locked, err);
        end
        run_frame(L, -1, 1'b0);
        compared++;
        if (ticks !== 0) begin
            mismatched++;
            $display("FAIL sat_resync_tick: got %0d want 0", ticks);
        end
        run_frame(L, -1, 1'b0);
        compared++;
        if (ticks !== 1 || tick_locked !== 1'b0 || tick_err !== 1'b1) begin
            mismatched++;
            $display("FAIL sat_first_publish: got ticks=%0d locked=%0b err=%0b want 1/0/1",
                     ticks, tick_locked, tick_err);
        end
    endtask

    task automatic test_coincident;
        int            exp_t [5] = '{0, 0, 1, 1, 1};
        logic [CW-1:0] exp_m [4] = '{10'd24, 10'd4, 10'd12, 10'd8};
        do_reset();
        for (int f = 0; f < 5; f++) begin
            run_frame(L, -1, 1'b1);
            compared++;
            if (ticks !== exp_t[f]) begin
                mismatched++;
                $display("FAIL coinc_ticks f%0d: got %0d want %0d", f, ticks, exp_t[f]);
            end
            if (f >= 2) begin
                compared++;
                if (tick_locked !== (f >= 3)) begin
                    mismatched++;
                    $display("FAIL coinc_locked f%0d: got %0b want %0b", f, tick_locked, (f >= 3));
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (cap[i] !== exp_m[i]) begin
                mismatched++;
                $display("FAIL coinc_meas sel%0d: got %0d want %0d", i, cap[i], exp_m[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_reset_midframe();
        test_short_frame();
        test_unstable();
        test_saturation();
        test_coincident();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
